// File: rtl/rx_mac_filter_if.sv
// AXI4-Stream beat bundle with the packet-level tuser sideband used on the
// adapter RX path.
interface rx_mac_filter_if;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic [15:0]  tuser_size;
  logic [15:0]  tuser_src;
  logic [15:0]  tuser_dst;

  modport master (output tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
                  input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
                  output tready);
endinterface

// File: rtl/rx_mac_filter.sv
// RX destination-MAC filter: per-packet accept/drop on the SOP beat, 2-entry skid
// output buffer, saturating pass/drop counters. Optional MAC_FILTER_PROMISC_EN adds cfg_promisc.
module rx_mac_filter #(
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit ACCEPT_MCAST = 1'b0,
  parameter int CNT_W        = 32
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  rx_mac_filter_if.slave    s_axis,
  rx_mac_filter_if.master   m_axis,
  input  logic [47:0]       cfg_local_mac,
`ifdef MAC_FILTER_PROMISC_EN
  input  logic              cfg_promisc,
`endif
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  stat_pass_pkts,
  output logic [CNT_W-1:0]  stat_drop_pkts
);

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [15:0]  size;
    logic [15:0]  src;
    logic [15:0]  dst;
  } beat_t;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  state_e           state_q;
  beat_t            in_beat, main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic [CNT_W-1:0] pass_q, drop_q;
  logic             hdr_ok, dst_match, accept, s_hs, sop_hs, push;
  logic [47:0]      dst_mac;

  assign in_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast,
                     size: s_axis.tuser_size, src: s_axis.tuser_src, dst: s_axis.tuser_dst};

  assign dst_mac   = s_axis.tdata[47:0];
  assign hdr_ok    = &s_axis.tkeep[13:0];
  assign dst_match = (dst_mac == cfg_local_mac)
                   | (ACCEPT_BCAST & (&dst_mac))
                   | (ACCEPT_MCAST & s_axis.tdata[0])
`ifdef MAC_FILTER_PROMISC_EN
                   | cfg_promisc
`endif
                   ;
  assign accept = hdr_ok & dst_match;

  // Ready is forced high in DROP, which never pushes, so skid overflow is impossible.
  assign s_axis.tready = rdy_q | (state_q == DROP);
  assign s_hs   = s_axis.tvalid & s_axis.tready;
  assign sop_hs = s_hs & (state_q == IDLE);
  assign push   = s_hs & (((state_q == IDLE) & accept) | (state_q == PASS));

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || m_axis.tready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q    <= IDLE;
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      pass_q     <= '0;
      drop_q     <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
      if (s_hs) begin
        case (state_q)
          IDLE:    state_q <= s_axis.tlast ? IDLE : (accept ? PASS : DROP);
          default: state_q <= s_axis.tlast ? IDLE : state_q;
        endcase
      end
      // Clear takes priority over a coincident SOP increment.
      if (stat_clear) begin
        pass_q <= '0;
        drop_q <= '0;
      end else if (sop_hs) begin
        if (accept && pass_q != {CNT_W{1'b1}})  pass_q <= pass_q + CNT_W'(1);
        if (!accept && drop_q != {CNT_W{1'b1}}) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign m_axis.tvalid     = main_vld_q;
  assign m_axis.tdata      = main_q.data;
  assign m_axis.tkeep      = main_q.keep;
  assign m_axis.tlast      = main_q.last;
  assign m_axis.tuser_size = main_q.size;
  assign m_axis.tuser_src  = main_q.src;
  assign m_axis.tuser_dst  = main_q.dst;
  assign stat_pass_pkts    = pass_q;
  assign stat_drop_pkts    = drop_q;

endmodule
